// File: rtl/func_sequencer.sv
// Function-code sequencer for the X/Y/Z/ULA datapath: CLR, three handshaked
// operand loads, SHIFTS x DIV, RES, then back to idle (DIS).
module func_sequencer #(
    parameter int WIDTH  = 8,
    parameter int SHIFTS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_data,
    output logic             op_ready,
    output logic [WIDTH-1:0] operand,
    output logic [3:0]       func,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] F_CLR = 4'b0000;
    localparam logic [3:0] F_LD1 = 4'b0001;
    localparam logic [3:0] F_LD2 = 4'b0010;
    localparam logic [3:0] F_LD3 = 4'b0011;
    localparam logic [3:0] F_DIV = 4'b0100;
    localparam logic [3:0] F_RES = 4'b0101;
    localparam logic [3:0] F_DIS = 4'b0110;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_CLR  = 4'd1;
    localparam logic [3:0] S_W1   = 4'd2;
    localparam logic [3:0] S_L1   = 4'd3;
    localparam logic [3:0] S_W2   = 4'd4;
    localparam logic [3:0] S_L2   = 4'd5;
    localparam logic [3:0] S_W3   = 4'd6;
    localparam logic [3:0] S_L3   = 4'd7;
    localparam logic [3:0] S_SH   = 4'd8;
    localparam logic [3:0] S_RS   = 4'd9;
    localparam logic [3:0] S_ACLR = 4'd10;

    localparam logic [3:0] SH_LOAD = 4'(SHIFTS - 1);

    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] cnt;
    logic [3:0] func_next;
    logic       accept;

    // Handshake: an operand transfers on a rising edge where op_valid and
    // op_ready are both high; abort in the same cycle cancels the transfer.
    assign accept = op_valid & op_ready & ~abort;

    always_comb begin
        next_state = state;
        if (abort && state != S_IDLE && state != S_ACLR) begin
            next_state = S_ACLR;
        end else begin
            case (state)
                S_IDLE:  if (start) next_state = S_CLR;
                S_CLR:   next_state = S_W1;
                S_W1:    if (accept) next_state = S_L1;
                S_L1:    next_state = S_W2;
                S_W2:    if (accept) next_state = S_L2;
                S_L2:    next_state = S_W3;
                S_W3:    if (accept) next_state = S_L3;
                S_L3:    next_state = S_SH;
                S_SH:    if (cnt == 4'd0) next_state = S_RS;
                S_RS:    next_state = S_IDLE;
                S_ACLR:  next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from next_state so they are registered alongside it.
    always_comb begin
        func_next = F_DIS;
        case (next_state)
            S_CLR, S_ACLR: func_next = F_CLR;
            S_L1:          func_next = F_LD1;
            S_L2:          func_next = F_LD2;
            S_L3:          func_next = F_LD3;
            S_SH:          func_next = F_DIV;
            S_RS:          func_next = F_RES;
            default:       func_next = F_DIS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= SH_LOAD;
            func     <= F_CLR;
            op_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            operand  <= '0;
        end else begin
            state    <= next_state;
            cnt      <= (state == S_SH) ? cnt - 4'd1 : SH_LOAD;
            func     <= func_next;
            op_ready <= (next_state == S_W1) || (next_state == S_W2) ||
                        (next_state == S_W3);
            busy     <= (next_state != S_IDLE);
            done     <= (state == S_RS) && (next_state == S_IDLE);
            if (accept) begin
                operand <= op_data;
            end
        end
    end

endmodule

// File: tb/tb_func_sequencer.sv
// Bench for func_sequencer: a vector table (SHIFTS=1 and SHIFTS=3 instances)
// plus hand-written reset sequences, checked through an expected-value queue.
module tb_func_sequencer;

    localparam logic [3:0] CLR = 4'b0000;
    localparam logic [3:0] LD1 = 4'b0001;
    localparam logic [3:0] LD2 = 4'b0010;
    localparam logic [3:0] LD3 = 4'b0011;
    localparam logic [3:0] DIV = 4'b0100;
    localparam logic [3:0] RES = 4'b0101;
    localparam logic [3:0] DIS = 4'b0110;
    localparam int W = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    logic       abort = 1'b0;
    logic       op_valid = 1'b0;
    logic [7:0] op_data = 8'h00;

    logic       op_ready, busy, done;
    logic [7:0] operand;
    logic [3:0] func;
    logic       op_ready3, busy3, done3;
    logic [7:0] operand3;
    logic [3:0] func3;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        bit         sel;
        logic       start;
        logic       abort;
        logic       valid;
        logic [7:0] data;
        logic [W-1:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[$];

    func_sequencer #(.WIDTH(8), .SHIFTS(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
        .operand(operand), .func(func), .busy(busy), .done(done)
    );

    func_sequencer #(.WIDTH(8), .SHIFTS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort),
        .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready3),
        .operand(operand3), .func(func3), .busy(busy3), .done(done3)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] pk(input logic [3:0] f, input logic r,
                                        input logic b, input logic dn,
                                        input logic [7:0] o);
        return {f, r, b, dn, o};
    endfunction

    function automatic void add(input bit sel, input logic s, input logic a,
                                input logic v, input logic [7:0] d,
                                input logic [W-1:0] e, input string name);
        vec_t t;
        t.sel = sel; t.start = s; t.abort = a; t.valid = v; t.data = d;
        t.exp = e; t.name = name;
        vecs.push_back(t);
    endfunction

    // scoreboard: pop the oldest expectation and compare to the chosen DUT
    task automatic compare(input bit sel, input string name);
        logic [W-1:0] got;
        logic [W-1:0] e;
        got = sel ? {func3, op_ready3, busy3, done3, operand3}
                  : {func, op_ready, busy, done, operand};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got func=%h rdy=%b busy=%b done=%b operand=%h, expected func=%h rdy=%b busy=%b done=%b operand=%h",
                     name, got[14:11], got[10], got[9], got[8], got[7:0],
                     e[14:11], e[10], e[9], e[8], e[7:0]);
        end
    endtask

    // driver: apply inputs for one cycle, check outputs after the edge
    task automatic step(input bit sel, input logic s, input logic a,
                        input logic v, input logic [7:0] d,
                        input logic [W-1:0] e, input string name);
        @(negedge clk);
        if (sel) start3 = s; else start = s;
        abort = a; op_valid = v; op_data = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; start3 = 1'b0;
        compare(sel, name);
    endtask

    initial begin
        // after-reset idle
        add(0, 0, 0, 0, 8'h00, pk(DIS, 0, 0, 0, 8'h00), "post_reset_idle");
        // basic run, SHIFTS=1, zero-wait producer
        add(0, 1, 0, 1, 8'h05, pk(CLR, 0, 1, 0, 8'h00), "run_clr");
        add(0, 0, 0, 1, 8'h05, pk(DIS, 1, 1, 0, 8'h00), "run_w1");
        add(0, 0, 0, 1, 8'h05, pk(LD1, 0, 1, 0, 8'h05), "run_l1");
        add(0, 0, 0, 1, 8'h07, pk(DIS, 1, 1, 0, 8'h05), "run_w2");
        add(0, 0, 0, 1, 8'h07, pk(LD2, 0, 1, 0, 8'h07), "run_l2");
        add(0, 0, 0, 1, 8'h09, pk(DIS, 1, 1, 0, 8'h07), "run_w3");
        add(0, 0, 0, 1, 8'h09, pk(LD3, 0, 1, 0, 8'h09), "run_l3");
        add(0, 0, 0, 0, 8'h00, pk(DIV, 0, 1, 0, 8'h09), "run_sh");
        add(0, 0, 0, 0, 8'h00, pk(RES, 0, 1, 0, 8'h09), "run_rs");
        add(0, 0, 0, 0, 8'h00, pk(DIS, 0, 0, 1, 8'h09), "run_done");
        add(0, 0, 0, 0, 8'h00, pk(DIS, 0, 0, 0, 8'h09), "run_idle");
        // SHIFTS=3 instance: three consecutive DIV cycles
        add(1, 1, 0, 1, 8'h01, pk(CLR, 0, 1, 0, 8'h00), "s3_clr");
        add(1, 0, 0, 1, 8'h01, pk(DIS, 1, 1, 0, 8'h00), "s3_w1");
        add(1, 0, 0, 1, 8'h01, pk(LD1, 0, 1, 0, 8'h01), "s3_l1");
        add(1, 0, 0, 1, 8'h02, pk(DIS, 1, 1, 0, 8'h01), "s3_w2");
        add(1, 0, 0, 1, 8'h02, pk(LD2, 0, 1, 0, 8'h02), "s3_l2");
        add(1, 0, 0, 1, 8'h03, pk(DIS, 1, 1, 0, 8'h02), "s3_w3");
        add(1, 0, 0, 1, 8'h03, pk(LD3, 0, 1, 0, 8'h03), "s3_l3");
        add(1, 0, 0, 0, 8'h00, pk(DIV, 0, 1, 0, 8'h03), "s3_sh1");
        add(1, 0, 0, 0, 8'h00, pk(DIV, 0, 1, 0, 8'h03), "s3_sh2");
        add(1, 0, 0, 0, 8'h00, pk(DIV, 0, 1, 0, 8'h03), "s3_sh3");
        add(1, 0, 0, 0, 8'h00, pk(RES, 0, 1, 0, 8'h03), "s3_rs");
        add(1, 0, 0, 0, 8'h00, pk(DIS, 0, 0, 1, 8'h03), "s3_done");
        add(1, 0, 0, 0, 8'h00, pk(DIS, 0, 0, 0, 8'h03), "s3_idle");
        // producer stalls four cycles in W2
        add(0, 1, 0, 0, 8'h00, pk(CLR, 0, 1, 0, 8'h09), "stall_clr");
        add(0, 0, 0, 1, 8'h11, pk(DIS, 1, 1, 0, 8'h09), "stall_w1");
        add(0, 0, 0, 1, 8'h11, pk(LD1, 0, 1, 0, 8'h11), "stall_l1");
        add(0, 0, 0, 0, 8'h00, pk(DIS, 1, 1, 0, 8'h11), "stall_w2_a");
        add(0, 0, 0, 0, 8'h00, pk(DIS, 1, 1, 0, 8'h11), "stall_w2_b");
        add(0, 0, 0, 0, 8'h00, pk(DIS, 1, 1, 0, 8'h11), "stall_w2_c");
        add(0, 0, 0, 0, 8'h00, pk(DIS, 1, 1, 0, 8'h11), "stall_w2_d");
        add(0, 0, 0, 1, 8'h22, pk(LD2, 0, 1, 0, 8'h22), "stall_l2");
        add(0, 0, 0, 1, 8'h33, pk(DIS, 1, 1, 0, 8'h22), "stall_w3");
        add(0, 0, 0, 1, 8'h33, pk(LD3, 0, 1, 0, 8'h33), "stall_l3");
        add(0, 0, 0, 0, 8'h00, pk(DIV, 0, 1, 0, 8'h33), "stall_sh");
        add(0, 0, 0, 0, 8'h00, pk(RES, 0, 1, 0, 8'h33), "stall_rs");
        add(0, 0, 0, 0, 8'h00, pk(DIS, 0, 0, 1, 8'h33), "stall_done");
        // abort in W2 together with a handshake
        add(0, 1, 0, 0, 8'h00, pk(CLR, 0, 1, 0, 8'h33), "abort_run_clr");
        add(0, 0, 0, 1, 8'h44, pk(DIS, 1, 1, 0, 8'h33), "abort_run_w1");
        add(0, 0, 0, 1, 8'h44, pk(LD1, 0, 1, 0, 8'h44), "abort_run_l1");
        add(0, 0, 0, 0, 8'h00, pk(DIS, 1, 1, 0, 8'h44), "abort_run_w2");
        add(0, 0, 1, 1, 8'h3C, pk(CLR, 0, 1, 0, 8'h44), "abort_clr");
        add(0, 0, 1, 1, 8'h3C, pk(DIS, 0, 0, 0, 8'h44), "abort_idle");
        add(0, 0, 1, 0, 8'h00, pk(DIS, 0, 0, 0, 8'h44), "abort_in_idle");
        // start and op_valid pulses while busy / not ready
        add(0, 1, 0, 1, 8'h55, pk(CLR, 0, 1, 0, 8'h44), "ign_clr");
        add(0, 0, 0, 1, 8'h55, pk(DIS, 1, 1, 0, 8'h44), "ign_w1");
        add(0, 0, 0, 1, 8'h55, pk(LD1, 0, 1, 0, 8'h55), "ign_l1");
        add(0, 1, 0, 1, 8'h66, pk(DIS, 1, 1, 0, 8'h55), "ign_start_l1");
        add(0, 0, 0, 1, 8'h66, pk(LD2, 0, 1, 0, 8'h66), "ign_l2");
        add(0, 1, 0, 1, 8'h77, pk(DIS, 1, 1, 0, 8'h66), "ign_start_l2");
        add(0, 0, 0, 1, 8'h77, pk(LD3, 0, 1, 0, 8'h77), "ign_l3");
        add(0, 1, 0, 1, 8'h88, pk(DIV, 0, 1, 0, 8'h77), "ign_sh");
        add(0, 1, 0, 1, 8'h99, pk(RES, 0, 1, 0, 8'h77), "ign_rs");
        add(0, 0, 0, 0, 8'h00, pk(DIS, 0, 0, 1, 8'h77), "ign_done");
        // start+abort in the done cycle starts normally; abort in W1 with handshake
        add(0, 1, 1, 0, 8'h00, pk(CLR, 0, 1, 0, 8'h77), "restart_clr");
        add(0, 0, 0, 0, 8'h00, pk(DIS, 1, 1, 0, 8'h77), "restart_w1");
        add(0, 0, 1, 1, 8'hAA, pk(CLR, 0, 1, 0, 8'h77), "restart_abort");
        add(0, 0, 0, 0, 8'h00, pk(DIS, 0, 0, 0, 8'h77), "restart_idle");

        // reset state, held in reset
        rst_n = 1'b0;
        #12;
        exp_q.push_back(pk(CLR, 0, 0, 0, 8'h00));
        compare(0, "reset_state");
        exp_q.push_back(pk(CLR, 0, 0, 0, 8'h00));
        compare(1, "reset_state_s3");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].sel, vecs[i].start, vecs[i].abort, vecs[i].valid,
                 vecs[i].data, vecs[i].exp, vecs[i].name);
        end

        // asynchronous reset in the middle of SH
        step(0, 1, 0, 1, 8'hA1, pk(CLR, 0, 1, 0, 8'h77), "rst_clr");
        step(0, 0, 0, 1, 8'hA1, pk(DIS, 1, 1, 0, 8'h77), "rst_w1");
        step(0, 0, 0, 1, 8'hA1, pk(LD1, 0, 1, 0, 8'hA1), "rst_l1");
        step(0, 0, 0, 1, 8'hB2, pk(DIS, 1, 1, 0, 8'hA1), "rst_w2");
        step(0, 0, 0, 1, 8'hB2, pk(LD2, 0, 1, 0, 8'hB2), "rst_l2");
        step(0, 0, 0, 1, 8'hC3, pk(DIS, 1, 1, 0, 8'hB2), "rst_w3");
        step(0, 0, 0, 1, 8'hC3, pk(LD3, 0, 1, 0, 8'hC3), "rst_l3");
        step(0, 0, 0, 0, 8'h00, pk(DIV, 0, 1, 0, 8'hC3), "rst_sh");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(pk(CLR, 0, 0, 0, 8'h00));
        compare(0, "rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 8'h00, pk(DIS, 0, 0, 0, 8'h00), "rst_release");
        step(0, 1, 0, 1, 8'h12, pk(CLR, 0, 1, 0, 8'h00), "rerun_clr");
        step(0, 0, 0, 1, 8'h12, pk(DIS, 1, 1, 0, 8'h00), "rerun_w1");
        step(0, 0, 0, 1, 8'h12, pk(LD1, 0, 1, 0, 8'h12), "rerun_l1");
        step(0, 0, 0, 1, 8'h34, pk(DIS, 1, 1, 0, 8'h12), "rerun_w2");
        step(0, 0, 0, 1, 8'h34, pk(LD2, 0, 1, 0, 8'h34), "rerun_l2");
        step(0, 0, 0, 1, 8'h56, pk(DIS, 1, 1, 0, 8'h34), "rerun_w3");
        step(0, 0, 0, 1, 8'h56, pk(LD3, 0, 1, 0, 8'h56), "rerun_l3");
        step(0, 0, 0, 0, 8'h00, pk(DIV, 0, 1, 0, 8'h56), "rerun_sh");
        step(0, 0, 0, 0, 8'h00, pk(RES, 0, 1, 0, 8'h56), "rerun_rs");
        step(0, 0, 0, 0, 8'h00, pk(DIS, 0, 0, 1, 8'h56), "rerun_done");

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/func_sequencer.md
Name: func_sequencer

Overview:
- Issues the 4-bit function codes that the control-unit decoder turns into register controls (tX/tY/tZ/tULA) for the X/Y/Z/ULA datapath.
- Runs one calculation per start pulse: CLR, three operand loads, DIV repeated SHIFTS times, then RES, then DIS.
- Accepts each operand over a valid/ready handshake and holds it stable on operand while the matching LDn code is on func.

Parameters:
- WIDTH, 8, operand data width.
- SHIFTS, 1, number of consecutive DIV cycles issued (legal range 1..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a calculation; sampled only in IDLE.
- abort  input  1  cancel the calculation in progress; sampled in every state except IDLE.
- op_valid  input  1  producer has an operand on op_data.
- op_data  input  WIDTH  operand value.
- op_ready  output  1  sequencer accepts an operand this cycle.
- operand  output  WIDTH  registered operand driven to the datapath.
- func  output  4  function code to the control unit.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a result has been loaded into Z.

Behaviour:
- Function codes: CLR=0000, LD1=0001, LD2=0010, LD3=0011, DIV=0100, RES=0101, DIS=0110. Codes 0111..1111 are never driven.
- All outputs are registered.
- Reset (rst_n low, asynchronous): state=IDLE, func=CLR, operand=0, op_ready=0, busy=0, done=0.
- First clock after reset release: func=DIS.
- States and func driven in each:
  - IDLE: func=DIS.
  - CLR: func=CLR.
  - W1, W2, W3: func=DIS, op_ready=1.
  - L1, L2, L3: func=LD1, LD2, LD3.
  - SH: func=DIV.
  - RS: func=RES.
- Transitions:
  - IDLE -start-> CLR -> W1.
  - Wn -(op_valid & op_ready)-> Ln; otherwise stay in Wn.
  - L1 -> W2, L2 -> W3, L3 -> SH.
  - SH holds for exactly SHIFTS cycles, using an internal 4-bit counter loaded with SHIFTS-1 on entry, then -> RS.
  - RS -> IDLE, with done=1 in the first IDLE cycle only.
- Latency:
  - start high at edge t -> func=CLR during cycle t+1 -> op_ready=1 from cycle t+2.
  - Zero-wait producer: total busy cycles = 8+SHIFTS.
- Handshake:
  - op_data is captured into operand on the accepting edge.
  - op_ready drops the cycle after acceptance.
  - operand keeps that value through the Ln cycle and stays unchanged until the next acceptance.
  - op_valid while op_ready=0 is ignored; nothing is queued.
- start while busy is ignored.
- abort in any busy state:
  - Next cycle is CLR (func=CLR, op_ready=0), then IDLE; done is not pulsed.
  - A handshake in the same cycle as abort is discarded: operand is not updated.
  - abort asserted during the abort-CLR cycle has no extra effect.
- abort in IDLE is ignored; start+abort together in IDLE starts normally.
- start in the same cycle as the done pulse (IDLE) starts a new run immediately.
- Reset mid-operation: outputs return to their reset values immediately (asynchronously), with no CLR cycle sequenced.

Test Plan:
- Reset, then start pulse with op_valid held high and op_data 5, 7, 9 → func sequence CLR, DIS, LD1, DIS, LD2, DIS, LD3, DIV, RES, DIS. operand equals 5, 7 and 9 during LD1, LD2 and LD3 respectively. done pulses once, 9 cycles after the CLR cycle. busy is high for exactly 9 cycles.
- SHIFTS=3 → exactly three consecutive DIV cycles between LD3 and RES.
- Producer delays op_valid for 4 cycles in W2 → func stays DIS with op_ready=1 for those 4 cycles; LD2 appears the cycle after the handshake.
- abort asserted in W2 together with op_valid and op_data=0x3C → func=CLR next cycle, then IDLE. operand keeps the first operand value. done stays 0.
- start while busy at L1, and op_valid pulses while op_ready=0 → sequence unchanged; no extra loads.
- rst_n asserted low during SH → func=CLR and busy=0 immediately without a clock edge. After release, func=DIS and the next start runs a full sequence.
